// File: rtl/ifetch_unit.sv
// ifetch_unit: fetch stage, one imem req/ack per PC, {pc, inst} queue to decode.
// Optional `IFETCH_ALIGN_CHECK_EN: misaligned PCs become faulted NOP entries.
module ifetch_unit #(
   parameter int unsigned DEPTH    = 2,
   parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] pc_i,
   output logic        pc_stall_o,
   input  logic        flush_i,
   output logic        imem_req_o,
   output logic [31:0] imem_addr_o,
   input  logic        imem_ack_i,
   input  logic [31:0] imem_rdata_i,
   output logic        inst_valid_o,
   input  logic        inst_ready_i,
   output logic [31:0] inst_o,
   output logic [31:0] inst_pc_o,
   output logic        inst_fault_o
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
   localparam logic [AW:0] ONE  = (AW+1)'(1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_WAIT,
      S_DRAIN
   } state_e;

   state_e      state_q, state_d;
   logic [31:0] req_pc_q, req_pc_d;
   logic [AW:0] wptr_q, wptr_d;
   logic [AW:0] rptr_q, rptr_d;
   logic [AW:0] count;

   logic [31:0] mem_pc_q   [DEPTH];
   logic [31:0] mem_inst_q [DEPTH];

   logic        space;
   logic        misal;
   logic        push;
   logic        pop;
   logic [31:0] push_pc;
   logic [31:0] push_inst;
   logic        push_fault;

   assign count        = wptr_q - rptr_q;
   assign space        = count < FULL;
   assign inst_valid_o = count != '0;
   assign pop          = inst_valid_o & inst_ready_i;
   assign imem_req_o   = state_q != S_IDLE;
   assign imem_addr_o  = {req_pc_q[31:2], 2'b00};
   assign push_inst    = push_fault ? NOP_WORD : imem_rdata_i;
   assign inst_o       = mem_inst_q[rptr_q[AW-1:0]];
   assign inst_pc_o    = mem_pc_q[rptr_q[AW-1:0]];

`ifdef IFETCH_ALIGN_CHECK_EN
   logic mem_fault_q [DEPTH];

   assign misal        = pc_i[1:0] != 2'b00;
   assign inst_fault_o = mem_fault_q[rptr_q[AW-1:0]];
`else
   assign misal        = 1'b0;
   assign inst_fault_o = 1'b0;
`endif

   // FSM state and latched request PC
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= S_IDLE;
         req_pc_q <= '0;
      end else begin
         state_q  <= state_d;
         req_pc_q <= req_pc_d;
      end
   end

   // next state, push request and PC stall
   always_comb begin
      state_d    = state_q;
      req_pc_d   = req_pc_q;
      push       = 1'b0;
      push_pc    = req_pc_q;
      push_fault = 1'b0;
      pc_stall_o = 1'b1;
      unique case (state_q)
         S_IDLE: begin
            if (!flush_i && space) begin
               if (misal) begin
                  push       = 1'b1;
                  push_pc    = pc_i;
                  push_fault = 1'b1;
                  pc_stall_o = 1'b0;
               end else begin
                  req_pc_d = pc_i;
                  state_d  = S_WAIT;
               end
            end
         end
         S_WAIT: begin
            if (imem_ack_i) begin
               state_d = S_IDLE;
               if (!flush_i) begin
                  push       = 1'b1;
                  pc_stall_o = 1'b0;
               end
            end else if (flush_i) begin
               state_d = S_DRAIN;
            end
         end
         S_DRAIN: begin
            if (imem_ack_i) begin
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
      if (flush_i) begin
         pc_stall_o = 1'b0;
      end
   end

   // queue pointer update; flush empties the queue
   always_comb begin
      wptr_d = wptr_q;
      rptr_d = rptr_q;
      if (flush_i) begin
         wptr_d = '0;
         rptr_d = '0;
      end else begin
         if (push) wptr_d = wptr_q + ONE;
         if (pop)  rptr_d = rptr_q + ONE;
      end
   end

   // queue pointer registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wptr_q <= '0;
         rptr_q <= '0;
      end else begin
         wptr_q <= wptr_d;
         rptr_q <= rptr_d;
      end
   end

   // queue storage, cleared on reset so the head reads 0
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int unsigned i = 0; i < DEPTH; i++) begin
            mem_pc_q[i]   <= '0;
            mem_inst_q[i] <= '0;
`ifdef IFETCH_ALIGN_CHECK_EN
            mem_fault_q[i] <= 1'b0;
`endif
         end
      end else if (push && !flush_i) begin
         mem_pc_q[wptr_q[AW-1:0]]   <= push_pc;
         mem_inst_q[wptr_q[AW-1:0]] <= push_inst;
`ifdef IFETCH_ALIGN_CHECK_EN
         mem_fault_q[wptr_q[AW-1:0]] <= push_fault;
`endif
      end
   end

endmodule

// File: tb/tb_ifetch_unit.sv
// tb_ifetch_unit: table of fetches plus hand-written flush/backpressure
// sequences; a queue of expected entries is checked on every pop.
module tb_ifetch_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] pc_i;
   logic        pc_stall_o;
   logic        flush_i;
   logic        imem_req_o;
   logic [31:0] imem_addr_o;
   logic        imem_ack_i;
   logic [31:0] imem_rdata_i;
   logic        inst_valid_o;
   logic        inst_ready_i;
   logic [31:0] inst_o;
   logic [31:0] inst_pc_o;
   logic        inst_fault_o;

   ifetch_unit dut (
      .clk          (clk),
      .rst          (rst),
      .pc_i         (pc_i),
      .pc_stall_o   (pc_stall_o),
      .flush_i      (flush_i),
      .imem_req_o   (imem_req_o),
      .imem_addr_o  (imem_addr_o),
      .imem_ack_i   (imem_ack_i),
      .imem_rdata_i (imem_rdata_i),
      .inst_valid_o (inst_valid_o),
      .inst_ready_i (inst_ready_i),
      .inst_o       (inst_o),
      .inst_pc_o    (inst_pc_o),
      .inst_fault_o (inst_fault_o)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] inst;
      logic        fault;
   } exp_t;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] rdata;
      int          delay;
   } vec_t;

   exp_t expq[$];
   vec_t vecs[6];
   int   errors = 0;
   int   checks = 0;

   task automatic check1(input string name, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %b expected %b", name, act, exp);
      end
   endtask

   task automatic check32(input string name, input logic [31:0] act,
                          input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      @(negedge clk);
   endtask

   // scoreboard: every accepted head must match the oldest expected entry
   always @(negedge clk) begin : mon
      exp_t e;
      if (!rst) begin
         if (inst_valid_o && inst_ready_i) begin
            if (expq.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL pop_unexpected: got pc %h, expected no entry",
                        inst_pc_o);
            end else begin
               e = expq.pop_front();
               check32("pop_pc", inst_pc_o, e.pc);
               check32("pop_inst", inst_o, e.inst);
               check1("pop_fault", inst_fault_o, e.fault);
            end
         end
         if (flush_i) expq.delete();
      end
   end

   // one fetch starting in S_IDLE; ack after 'delay' wait cycles
   task automatic fetch(input logic [31:0] pc, input logic [31:0] rdata,
                        input int delay);
      logic [31:0] a;
      a = {pc[31:2], 2'b00};
      pc_i = pc;
      imem_ack_i = 1'b0;
      settle();
      check1("idle_req", imem_req_o, 1'b0);
      check1("idle_stall", pc_stall_o, 1'b1);
      tick();
      for (int d = 0; d < delay; d++) begin
         settle();
         check1("wait_req", imem_req_o, 1'b1);
         check32("wait_addr", imem_addr_o, a);
         check1("wait_stall", pc_stall_o, 1'b1);
         tick();
      end
      imem_ack_i = 1'b1;
      imem_rdata_i = rdata;
      expq.push_back('{pc, rdata, 1'b0});
      settle();
      check1("ack_req", imem_req_o, 1'b1);
      check32("ack_addr", imem_addr_o, a);
      check1("ack_stall", pc_stall_o, 1'b0);
      tick();
      imem_ack_i = 1'b0;
      imem_rdata_i = 32'hDEAD_BEEF;
   endtask

   task automatic drain();
      inst_ready_i = 1'b1;
      for (int i = 0; i < 8 && expq.size() != 0; i++) tick();
      check32("drained", 32'(expq.size()), 32'h0);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      imem_ack_i = 1'b0;
      flush_i = 1'b0;
      inst_ready_i = 1'b1;
      tick();
      expq.delete();
      rst = 1'b0;
   endtask

   initial begin
      rst = 1'b1;
      pc_i = '0;
      flush_i = 1'b0;
      imem_ack_i = 1'b0;
      imem_rdata_i = '0;
      inst_ready_i = 1'b1;

      vecs[0] = '{32'h0000_3000, 32'h2008_0005, 0};
      vecs[1] = '{32'h0000_3004, 32'h1111_2222, 3};
      vecs[2] = '{32'h0000_3008, 32'hA5A5_5A5A, 0};
      vecs[3] = '{32'h0000_300C, 32'h0000_0013, 1};
      vecs[4] = '{32'hFFFF_FFFC, 32'hFFFF_FFFF, 2};
      vecs[5] = '{32'h0000_0000, 32'h8000_0001, 0};

      #2;
      check1("rst_req", imem_req_o, 1'b0);
      check32("rst_addr", imem_addr_o, 32'h0);
      check1("rst_stall", pc_stall_o, 1'b1);
      check1("rst_valid", inst_valid_o, 1'b0);
      check32("rst_inst", inst_o, 32'h0);
      check32("rst_pc", inst_pc_o, 32'h0);
      check1("rst_fault", inst_fault_o, 1'b0);
      tick();
      rst = 1'b0;

      // streaming fetches with decode always ready
      for (int i = 0; i < 6; i++) begin
         fetch(vecs[i].pc, vecs[i].rdata, vecs[i].delay);
      end
      settle();
      check1("stall_one_cycle", pc_stall_o, 1'b1);
      drain();

      // backpressure: full queue blocks the third request
      do_reset();
      inst_ready_i = 1'b0;
      fetch(32'h3000, 32'h0000_0A01, 0);
      fetch(32'h3004, 32'h0000_0A02, 0);
      pc_i = 32'h3008;
      for (int i = 0; i < 3; i++) begin
         settle();
         check1("full_req", imem_req_o, 1'b0);
         check1("full_stall", pc_stall_o, 1'b1);
         check1("full_valid", inst_valid_o, 1'b1);
         check32("full_head", inst_pc_o, 32'h3000);
         tick();
      end
      inst_ready_i = 1'b1;
      settle();
      check1("full_pop_req", imem_req_o, 1'b0);
      tick();
      inst_ready_i = 1'b0;
      fetch(32'h3008, 32'h0000_0A03, 0);
      drain();

      // flush while waiting: queue cleared, late data dropped
      do_reset();
      inst_ready_i = 1'b0;
      fetch(32'h3000, 32'h0000_0B01, 0);
      pc_i = 32'h3010;
      settle();
      tick();
      flush_i = 1'b1;
      settle();
      check1("fl_wait_req", imem_req_o, 1'b1);
      check1("fl_wait_stall", pc_stall_o, 1'b0);
      tick();
      flush_i = 1'b0;
      pc_i = 32'h3040;
      check1("fl_cleared", inst_valid_o, 1'b0);
      settle();
      check1("drain_req", imem_req_o, 1'b1);
      check32("drain_addr", imem_addr_o, 32'h3010);
      check1("drain_stall", pc_stall_o, 1'b1);
      tick();
      imem_ack_i = 1'b1;
      imem_rdata_i = 32'hBAD0_BAD0;
      settle();
      check1("drain_ack_stall", pc_stall_o, 1'b1);
      tick();
      imem_ack_i = 1'b0;
      check1("drain_no_push", inst_valid_o, 1'b0);
      check1("drain_idle", imem_req_o, 1'b0);
      inst_ready_i = 1'b1;
      fetch(32'h3040, 32'h0000_0B02, 0);
      drain();

      // flush coincident with ack and pop
      do_reset();
      inst_ready_i = 1'b0;
      fetch(32'h3000, 32'h0000_0C01, 0);
      pc_i = 32'h3004;
      settle();
      tick();
      imem_ack_i = 1'b1;
      imem_rdata_i = 32'h0000_0C02;
      flush_i = 1'b1;
      inst_ready_i = 1'b1;
      settle();
      check1("fa_stall", pc_stall_o, 1'b0);
      tick();
      imem_ack_i = 1'b0;
      flush_i = 1'b0;
      check1("fa_empty", inst_valid_o, 1'b0);
      check1("fa_idle", imem_req_o, 1'b0);
      fetch(32'h3080, 32'h0000_0C03, 0);
      drain();

      // misaligned PC
      do_reset();
`ifdef IFETCH_ALIGN_CHECK_EN
      inst_ready_i = 1'b0;
      pc_i = 32'h3002;
      settle();
      check1("mis_req", imem_req_o, 1'b0);
      check1("mis_stall", pc_stall_o, 1'b0);
      expq.push_back('{32'h3002, 32'h0, 1'b1});
      tick();
      pc_i = 32'h3004;
      check1("mis_valid", inst_valid_o, 1'b1);
      check32("mis_pc", inst_pc_o, 32'h3002);
      check32("mis_inst", inst_o, 32'h0);
      check1("mis_fault", inst_fault_o, 1'b1);
      inst_ready_i = 1'b1;
      fetch(32'h3004, 32'h0000_0D01, 0);
`else
      fetch(32'h3006, 32'h0000_0D01, 2);
`endif
      drain();

      // reset mid-wait, then a late ack
      do_reset();
      pc_i = 32'h3100;
      settle();
      tick();
      check1("mr_req_before", imem_req_o, 1'b1);
      #2;
      rst = 1'b1;
      #1;
      check1("mr_req_async", imem_req_o, 1'b0);
      check32("mr_addr", imem_addr_o, 32'h0);
      check1("mr_stall", pc_stall_o, 1'b1);
      tick();
      rst = 1'b0;
      expq.delete();
      imem_ack_i = 1'b1;
      imem_rdata_i = 32'h0000_0E01;
      settle();
      check1("late_ack_req", imem_req_o, 1'b0);
      tick();
      imem_ack_i = 1'b0;
      check1("late_ack_no_push", inst_valid_o, 1'b0);
      check1("late_ack_wait", imem_req_o, 1'b1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
